// File: rtl/char_buffer_writer_pkg.sv
// Shared constants for the 80x32 character buffer: geometry, control codes, writer state encoding.
// Also used by the VGA scan-out through char_addr_calc.
package char_buffer_writer_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 32;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 7;
    localparam int ADDR_W = 12;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_HT    = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [ROW_W-1:0]  LAST_ROW       = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL       = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CLEAR_ROW_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CLEAR_ALL_LAST = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        CLEAR_ROW = 2'd2,
        CLEAR_ALL = 2'd3
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_buffer_writer_addr_calc.sv
// char_addr_calc: maps (top_row, logical row, col) to a linear buffer address, phys*80 + col.
// The row sum wraps at 5 bits, which is what makes the rotating top_row scroll work.
module char_addr_calc
    import char_buffer_writer_pkg::*;
(
    input  logic [ROW_W-1:0]  top_row,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ROW_W-1:0] phys;

    assign phys = top_row + row;
    // phys*80 as phys*64 + phys*16; the largest result is 31*80+79 = 2559
    assign addr = {1'b0, phys, 6'b0} + {3'b0, phys, 4'b0} + {5'b0, col};

endmodule

// File: rtl/char_buffer_writer.sv
// Terminal-style writer for the 80x32 character buffer: cursor, wrap, LF/CR/BS/FF, scroll via top_row.
// Define CHAR_BUFFER_WRITER_TAB_EN to make HT (0x09) advance to the next multiple-of-8 column.
module char_buffer_writer
    import char_buffer_writer_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] buf_ad,
    output logic [7:0]        buf_din,
    output logic              buf_ce,
    output logic              buf_wre,
    output logic [ROW_W-1:0]  top_row,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    state_t            state, state_n;
    logic              we_r, we_n;
    logic [ADDR_W-1:0] ad_n, clr_cnt, clr_n;
    logic [7:0]        din_n;
    logic [ROW_W-1:0]  top_n, row_n;
    logic [COL_W-1:0]  col_n;
    logic [ADDR_W-1:0] cur_addr, scroll_addr;
    logic              accept, clr_done, at_bottom, do_nl;

    assign accept    = in_valid & in_ready;
    assign at_bottom = (cursor_row == LAST_ROW);
    assign clr_done  = (clr_cnt == ((state == CLEAR_ROW) ? CLEAR_ROW_LAST : CLEAR_ALL_LAST));

`ifdef CHAR_BUFFER_WRITER_TAB_EN
    logic [COL_W-1:0] tab_col;
    logic             tab_wraps;
    assign tab_col   = {cursor_col[6:3] + 4'd1, 3'b000};
    assign tab_wraps = (tab_col >= COL_W'(COLS));
`endif

    char_addr_calc u_cur_addr (
        .top_row (top_row),
        .row     (cursor_row),
        .col     (cursor_col),
        .addr    (cur_addr)
    );

    // The old top physical row becomes the new bottom line when scrolling.
    char_addr_calc u_scroll_addr (
        .top_row (top_row),
        .row     ('0),
        .col     ('0),
        .addr    (scroll_addr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_printable(in_data))                 state_n = WRITE;
                    else if (in_data == CH_FF)                 state_n = CLEAR_ALL;
                    else if (in_data == CH_LF && at_bottom)    state_n = CLEAR_ROW;
`ifdef CHAR_BUFFER_WRITER_TAB_EN
                    else if (in_data == CH_HT && tab_wraps && at_bottom) state_n = CLEAR_ROW;
`endif
                end
            end
            WRITE:     state_n = (cursor_col == LAST_COL && at_bottom) ? CLEAR_ROW : IDLE;
            CLEAR_ROW: if (clr_done) state_n = IDLE;
            CLEAR_ALL: if (clr_done) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        top_n = top_row;
        row_n = cursor_row;
        col_n = cursor_col;
        we_n  = 1'b0;
        ad_n  = buf_ad;
        din_n = buf_din;
        clr_n = clr_cnt;
        do_nl = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        we_n  = 1'b1;
                        ad_n  = cur_addr;
                        din_n = in_data;
                    end else begin
                        case (in_data)
                            CH_LF: do_nl = 1'b1;
                            CH_CR: col_n = '0;
                            CH_BS: if (cursor_col != '0) col_n = cursor_col - 7'd1;
                            CH_FF: begin
                                top_n = '0;
                                row_n = '0;
                                col_n = '0;
                                we_n  = 1'b1;
                                ad_n  = '0;
                                din_n = CH_SPACE;
                                clr_n = '0;
                            end
`ifdef CHAR_BUFFER_WRITER_TAB_EN
                            CH_HT: begin
                                if (tab_wraps) begin
                                    col_n = '0;
                                    do_nl = 1'b1;
                                end else begin
                                    col_n = tab_col;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (cursor_col == LAST_COL) begin
                    col_n = '0;
                    do_nl = 1'b1;
                end else begin
                    col_n = cursor_col + 7'd1;
                end
            end
            CLEAR_ROW, CLEAR_ALL: begin
                if (!clr_done) begin
                    we_n  = 1'b1;
                    ad_n  = buf_ad + 12'd1;
                    clr_n = clr_cnt + 12'd1;
                end
            end
            default: ;
        endcase
        // At the bottom line a newline scrolls instead and starts blanking the recycled row.
        if (do_nl) begin
            if (!at_bottom) begin
                row_n = cursor_row + 5'd1;
            end else begin
                top_n = top_row + 5'd1;
                we_n  = 1'b1;
                ad_n  = scroll_addr;
                din_n = CH_SPACE;
                clr_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            we_r       <= 1'b0;
            buf_ad     <= '0;
            buf_din    <= '0;
            clr_cnt    <= '0;
            top_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            in_ready   <= (state_n == IDLE);
            busy       <= (state_n == CLEAR_ROW) || (state_n == CLEAR_ALL);
            we_r       <= we_n;
            buf_ad     <= ad_n;
            buf_din    <= din_n;
            clr_cnt    <= clr_n;
            top_row    <= top_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
        end
    end

    assign buf_ce  = we_r;
    assign buf_wre = we_r;

endmodule

// File: doc/char_buffer_writer.md
# char_buffer_writer

Terminal-style writer for the 80x32 character buffer. Consumes a byte stream (keyboard/UART ASCII) over a valid/ready handshake, maintains a text cursor, and drives the write port of the character-buffer RAM. Line wrap, newline, backspace, and clear-screen are handled in hardware. Scrolling uses a rotating top-row pointer exported to the VGA scan-out, so no buffer copy is needed.

## Interface
- COLS, 80, characters per row
- ROWS, 32, rows (power of two; row index wraps mod ROWS)
- clk  input  1  system clock, all logic on posedge
- resetn  input  1  asynchronous active-low reset
- in_data  input  8  ASCII byte
- in_valid  input  1  in_data valid
- in_ready  output  1  writer can accept a byte this cycle
- buf_ad  output  12  buffer address, physical_row*80 + col
- buf_din  output  8  byte to write
- buf_ce  output  1  buffer enable; asserted only together with buf_wre
- buf_wre  output  1  write strobe
- top_row  output  5  physical row shown as screen line 0
- cursor_row  output  5  logical cursor row (0 = top of screen)
- cursor_col  output  7  cursor column 0..79
- busy  output  1  bulk clear in progress

## Operation
- Byte accepted on posedge where in_valid & in_ready. in_ready = (state==IDLE).
- States: IDLE, WRITE, CLEAR_ROW, CLEAR_ALL.
- Printable 0x20..0x7E: IDLE->WRITE. One cycle with buf_ce=buf_wre=1, buf_din=byte, address of current cursor. Then advance col. At col 79, advance to col 0, row+1 (newline rule).
- LF 0x0A: row+1 with col unchanged. CR 0x0D: col=0. BS 0x08: col-1 if col>0, else no effect; no erase write. Each is a single IDLE-cycle update with no write.
- Newline rule: if row<31, row+1. If row==31, row stays 31, top_row+1 (mod 32), then CLEAR_ROW.
- CLEAR_ROW: 80 writes of 0x20, one per cycle, col 0..79 of the new bottom physical row (the old top_row), then IDLE.
- FF 0x0C: CLEAR_ALL. 2560 writes of 0x20 to addresses 0..2559 ascending; top_row=0; cursor (0,0); then IDLE.
- All other bytes (0x00..0x1F unlisted, 0x7F..0xFF): consumed, no effect.
- Address arithmetic: phys = (top_row + cursor_row) mod 32 (5-bit wrap); buf_ad = (phys<<6)+(phys<<4)+col. Range 0..2559; never exceeds 12 bits.
- busy = state is CLEAR_ROW or CLEAR_ALL.

## Timing
- Reset: state IDLE, in_ready=1, buf_ce=buf_wre=0, buf_ad=0, buf_din=0, top_row=0, cursor 0,0, busy=0. Buffer contents are not cleared by reset.
- All outputs registered. Printable accepted at edge N: write cycle N..N+1, in_ready low for that cycle, high again after edge N+1. Sustained throughput is 1 char per 2 cycles.
- Control bytes: cursor updated at the acceptance edge; in_ready stays high.
- Wrap-induced scroll: WRITE -> CLEAR_ROW directly. Accept-to-ready is 82 cycles.
- CLEAR_ALL: 2560 write cycles; in_ready low throughout.
- Reset asserted mid-clear: aborts immediately. Partially cleared buffer is left as-is.
- cursor_row/col and top_row update at the same edge as the state transition that causes them.

## Configuration
- CHAR_BUFFER_WRITER_TAB_EN defined: HT 0x09 moves col to next multiple of 8. If that is ≥80, apply the newline rule with col=0. No write.
- Undefined: 0x09 is ignored like other unlisted control codes.

## Structure
- Shared package: COLS/ROWS constants, control-code constants (LF, CR, BS, FF, HT, SPACE), and state encoding.
- One natural sub-module: char_addr_calc (combinational top_row+row wrap and *80+col). It is reused by the VGA scan-out.

## Test plan
- Reset, send "AB" -> writes 0x41@0, 0x42@1; cursor (0,2); buf_ce low when idle.
- 80 'x' then 'y' -> 'y' written at address 80; cursor (1,1).
- At row 31, send LF -> top_row 0->1; 80 writes of 0x20 to addresses 0..79; busy high for 80 cycles; cursor_row stays 31.
- Cursor (5,10): BS, CR, BS -> col 9, 0, 0; no writes.
- FF with top_row=7 -> 2560 writes of 0x20, addresses 0..2559; top_row=0; cursor (0,0); then 'Z' written at address 0.
- TAB_EN defined, col 75, HT -> cursor (row+1, 0); undefined -> unchanged.
